// File: rtl/axi_read_arbiter.sv
// Two-client (instruction/data) AXI read arbiter with at most one burst outstanding.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; default is fixed data priority.
module axi_read_arbiter #(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic                  d_req,
  input  logic [BUS_WIDTH-1:0]  i_addr,
  input  logic [BUS_WIDTH-1:0]  d_addr,
  input  logic [7:0]            i_len,
  input  logic [7:0]            d_len,
  output logic                  i_ack,
  output logic                  d_ack,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  output logic [3:0]            ar_id,
  output logic [7:0]            ar_len,
  output logic [2:0]            ar_size,
  output logic [1:0]            ar_burst,
  output logic [BUS_WIDTH-1:0]  ar_addr,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [3:0]            rd_id,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_last
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t               state, state_next;
  logic                 grant;
  logic                 winner;
  logic [BUS_WIDTH-1:0] addr_q;
  logic [7:0]           len_q;
  logic [7:0]           beat_cnt;
  logic                 unused_rd_id;

  // Response ownership comes from the latched grant, so the returned ID is not needed.
  assign unused_rd_id = ^rd_id;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  always_comb begin
    winner = d_req;
    if (i_req && d_req) winner = ~last_grant;
  end

  always_ff @(posedge clk) begin
    if (!reset) last_grant <= 1'b1;
    else if (state == IDLE && (i_req || d_req)) last_grant <= winner;
  end
`else
  always_comb winner = d_req;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      grant    <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            grant  <= winner;
            addr_q <= winner ? d_addr : i_addr;
            len_q  <= winner ? d_len  : i_len;
          end
        end
        ADDR: begin
          if (ar_ready) beat_cnt <= '0;
        end
        DATA: begin
          if (rd_valid) beat_cnt <= beat_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    ar_valid   = 1'b0;
    i_ack      = 1'b0;
    d_ack      = 1'b0;
    rd_ready   = 1'b0;
    rsp_valid  = 1'b0;
    rsp_last   = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) state_next = ADDR;
      end
      ADDR: begin
        ar_valid = 1'b1;
        if (ar_ready) begin
          i_ack      = ~grant;
          d_ack      = grant;
          state_next = DATA;
        end
      end
      DATA: begin
        rd_ready  = 1'b1;
        rsp_valid = rd_valid;
        rsp_last  = rd_last;
        // rd_last ends the burst even if the beat count disagrees with ar_len.
        if (rd_valid && rd_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ar_addr  = addr_q;
  assign ar_len   = len_q;
  assign ar_id    = {3'b000, grant};
  assign ar_size  = 3'b010;
  assign ar_burst = 2'b01;
  assign rsp_id   = grant;
  assign rsp_data = rd_data;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: directed scenarios plus randomized
// request/slave traffic checked against a transaction-level arbitration model.
module tb_axi_read_arbiter;
  localparam int BW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req;
  logic [BW-1:0] i_addr, d_addr;
  logic [7:0]    i_len, d_len;
  logic          i_ack, d_ack;
  logic          rsp_valid, rsp_id, rsp_last;
  logic [DW-1:0] rsp_data;
  logic          ar_valid, ar_ready;
  logic [3:0]    ar_id;
  logic [7:0]    ar_len;
  logic [2:0]    ar_size;
  logic [1:0]    ar_burst;
  logic [BW-1:0] ar_addr;
  logic          rd_valid, rd_ready, rd_last;
  logic [3:0]    rd_id;
  logic [DW-1:0] rd_data;

  int   checks = 0;
  int   failures = 0;
  logic model_last = 1'b1;

  always #5 clk = ~clk;

  axi_read_arbiter #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .d_req(d_req), .i_addr(i_addr), .d_addr(d_addr),
    .i_len(i_len), .d_len(d_len), .i_ack(i_ack), .d_ack(d_ack),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_len(ar_len),
    .ar_size(ar_size), .ar_burst(ar_burst), .ar_addr(ar_addr),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_id(rd_id), .rd_data(rd_data),
    .rd_last(rd_last)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Winner of one arbitration round from the request set and the previous grant.
  function automatic logic pick(input logic ir, input logic dr);
    if (ir && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
      return ~model_last;
`else
      return 1'b1;
`endif
    end
    return dr;
  endfunction

  // Plays the AXI slave for one burst owned by client id and checks every cycle.
  task automatic serve(input logic id, input logic [31:0] addr, input logic [7:0] len,
                       input int unsigned ardly, input bit gaps, input int unsigned last_at);
    int unsigned waited;
    logic [31:0] dat;
    waited = 0;
    #1;
    while (!ar_valid && waited < 8) begin
      step(); #1;
      waited++;
    end
    check("ar_latency", 64'(waited), 64'd1);
    model_last = id;
    for (int unsigned k = 0; k < ardly; k++) begin
      check("hold_valid", 64'(ar_valid), 64'd1);
      check("hold_addr", 64'(ar_addr), 64'(addr));
      check("hold_len", 64'(ar_len), 64'(len));
      check("hold_noack", 64'({i_ack, d_ack}), 64'd0);
      step(); #1;
    end
    ar_ready = 1'b1;
    #1;
    check("ar_valid", 64'(ar_valid), 64'd1);
    check("ar_id", 64'(ar_id), 64'({3'b000, id}));
    check("ar_addr", 64'(ar_addr), 64'(addr));
    check("ar_len", 64'(ar_len), 64'(len));
    check("ar_size_burst", 64'({ar_size, ar_burst}), 64'({3'b010, 2'b01}));
    check("ack", 64'({i_ack, d_ack}), id ? 64'd1 : 64'd2);
    step();
    ar_ready = 1'b0;
    if (id) d_req = 1'b0; else i_req = 1'b0;
    #1;
    check("ack_pulse", 64'({i_ack, d_ack}), 64'd0);
    check("ar_drop", 64'(ar_valid), 64'd0);
    check("rd_ready", 64'(rd_ready), 64'd1);
    for (int unsigned b = 0; b <= last_at; b++) begin
      if (gaps) begin
        rd_valid = 1'b0;
        #1;
        check("gap_rsp", 64'(rsp_valid), 64'd0);
        step();
      end
      dat = $urandom;
      rd_valid = 1'b1;
      rd_data = dat;
      rd_last = (b == last_at);
      rd_id = 4'($urandom);
      #1;
      check("rsp_valid", 64'(rsp_valid), 64'd1);
      check("rsp_data", 64'(rsp_data), 64'(dat));
      check("rsp_id", 64'(rsp_id), 64'(id));
      check("rsp_last", 64'(rsp_last), 64'(b == last_at));
      step();
      rd_valid = 1'b0;
      rd_last = 1'b0;
    end
    #1;
    check("idle_rd_ready", 64'(rd_ready), 64'd0);
    check("idle_rsp", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    logic w, ir, dr;
    int unsigned p, la;
    reset = 1'b0;
    i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0; i_len = '0; d_len = '0;
    ar_ready = 1'b0; rd_valid = 1'b0; rd_last = 1'b0; rd_id = '0; rd_data = '0;
    step(); step(); #1;
    check("rst_ar_valid", 64'(ar_valid), 64'd0);
    check("rst_rd_ready", 64'(rd_ready), 64'd0);
    check("rst_acks", 64'({i_ack, d_ack}), 64'd0);
    check("rst_rsp", 64'({rsp_valid, rsp_last}), 64'd0);
    check("rst_ar_latch", 64'({ar_id, ar_len, ar_addr}), 64'd0);
    reset = 1'b1;
    step();

    // Single instruction burst of four beats.
    i_req = 1'b1; i_addr = 32'h8000_0000; i_len = 8'd3;
    serve(1'b0, 32'h8000_0000, 8'd3, 0, 1'b0, 3);

    // Two back-to-back simultaneous single-beat requests.
    repeat (2) begin
      i_req = 1'b1; d_req = 1'b1; i_len = 8'd0; d_len = 8'd0;
      i_addr = 32'h0000_1000; d_addr = 32'h0000_2000;
      w = pick(1'b1, 1'b1);
      serve(w, w ? d_addr : i_addr, 8'd0, 0, 1'b0, 0);
      serve(~w, w ? i_addr : d_addr, 8'd0, 0, 1'b0, 0);
    end

    // Address phase stalled for five cycles.
    d_req = 1'b1; d_addr = 32'h1234_5670; d_len = 8'd2;
    serve(1'b1, 32'h1234_5670, 8'd2, 5, 1'b0, 2);

    // Eight-beat burst with a gap before every beat.
    i_req = 1'b1; i_addr = 32'h0000_0040; i_len = 8'd7;
    serve(1'b0, 32'h0000_0040, 8'd7, 0, 1'b1, 7);

    // Reset in the middle of a data phase.
    d_req = 1'b1; d_addr = 32'h0000_0080; d_len = 8'd3;
    #1; step();
    ar_ready = 1'b1;
    step();
    ar_ready = 1'b0; d_req = 1'b0;
    repeat (2) begin
      rd_valid = 1'b1; rd_data = $urandom;
      #1;
      check("pre_rst_rsp", 64'(rsp_valid), 64'd1);
      step();
    end
    reset = 1'b0;
    step(); #1;
    check("mid_rst_ar_valid", 64'(ar_valid), 64'd0);
    check("mid_rst_rd_ready", 64'(rd_ready), 64'd0);
    check("mid_rst_rsp", 64'(rsp_valid), 64'd0);
    reset = 1'b1; rd_valid = 1'b0;
    model_last = 1'b1;
    step();
    d_req = 1'b1; d_addr = 32'h0000_0100; d_len = 8'd1;
    serve(1'b1, 32'h0000_0100, 8'd1, 0, 1'b0, 1);

    // Randomized traffic: request mix, stalls, gaps and early rd_last.
    for (int it = 0; it < 40; it++) begin
      p = $urandom_range(1, 3);
      ir = (p != 2);
      dr = (p != 1);
      i_req = ir; d_req = dr;
      i_addr = $urandom & 32'hFFFF_FFFC; d_addr = $urandom & 32'hFFFF_FFFC;
      i_len = 8'($urandom_range(0, 7)); d_len = 8'($urandom_range(0, 7));
      w = pick(ir, dr);
      la = ($urandom_range(0, 3) == 0) ? $urandom_range(0, w ? d_len : i_len) : (w ? d_len : i_len);
      serve(w, w ? d_addr : i_addr, w ? d_len : i_len, $urandom_range(0, 3), 1'($urandom), la);
      if (ir && dr) begin
        la = ($urandom_range(0, 3) == 0) ? $urandom_range(0, w ? i_len : d_len) : (w ? i_len : d_len);
        serve(~w, w ? i_addr : d_addr, w ? i_len : d_len, $urandom_range(0, 3), 1'($urandom), la);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Params: BUS_WIDTH, default 32, address width; DATA_WIDTH, default 32, beat width.
REQ-002 clk  in  1  single clock; all logic on posedge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 i_req / d_req  in  1 each  instruction-side / data-side read request; held until own ack.
REQ-005 i_addr / d_addr  in  BUS_WIDTH each  burst start address, word aligned.
REQ-006 i_len / d_len  in  8 each  beats minus one.
REQ-007 i_ack / d_ack  out  1 each  one-cycle pulse, request accepted on AR.
REQ-008 rsp_valid  out  1  response beat valid.
REQ-009 rsp_id  out  1  owner of the beat: 0 is inst, 1 is data.
REQ-010 rsp_data  out  DATA_WIDTH  response beat data.
REQ-011 rsp_last  out  1  final beat of the burst.
REQ-012 ar_valid  out  1; ar_ready  in  1  AXI read-address handshake.
REQ-013 ar_id  out  4; ar_len  out  8; ar_size  out  3; ar_burst  out  2; ar_addr  out  BUS_WIDTH.
REQ-014 rd_valid  in  1; rd_ready  out  1; rd_id  in  4; rd_data  in  DATA_WIDTH; rd_last  in  1.

Function
REQ-015 FSM states: IDLE, ADDR, DATA; one burst outstanding at most.
REQ-016 IDLE: any req present -> latch winner grant, addr, len -> ADDR next cycle; no req -> stay IDLE.
REQ-017 Arbitration on simultaneous i_req and d_req: data wins (see REQ-030 for alternate).
REQ-018 ADDR: ar_valid=1; ar_addr/ar_len from latches; ar_id = {3'b0, grant}; ar_size=3'b010; ar_burst=2'b01 (INCR).
REQ-019 ADDR: all ar_* outputs stable while ar_valid && !ar_ready.
REQ-020 ADDR: cycle with ar_valid && ar_ready -> pulse granted client's ack that same cycle -> DATA.
REQ-021 DATA: rd_ready=1; rsp_valid=rd_valid; rsp_data=rd_data; rsp_last=rd_last; rsp_id=latched grant, not rd_id; combinational pass-through, zero latency.
REQ-022 DATA: 8-bit beat counter increments on each rd_valid; rd_valid && rd_last -> IDLE next cycle.
REQ-023 rd_last when counter != latched len: accepted as end of burst, no error; counter reset to 0 on DATA entry.
REQ-024 rd_ready=0 and rsp_valid=0 outside DATA; rd_valid outside DATA ignored.
REQ-025 len=0: single beat, rd_last on first beat, back to IDLE.
REQ-026 Loser request stays pending; served from IDLE after current burst, no cycle lost beyond the IDLE cycle.

Reset
REQ-027 reset low at posedge: state=IDLE, grant=0, counter=0, latches cleared; ar_valid=0, rd_ready=0, i_ack=0, d_ack=0, rsp_valid=0, rsp_last=0.
REQ-028 Reset mid-ADDR or mid-DATA: burst abandoned, no ack, no further rsp beats; first post-reset request starts from IDLE.

Configuration
REQ-029 Macro ARB_ROUND_ROBIN_EN selects arbitration policy.
REQ-030 Defined: on simultaneous requests winner = client not granted last; last-grant flag reset to data (so inst wins first tie). Undefined: fixed data priority per REQ-017.

Verification
REQ-031 i_req, i_addr=0x8000_0000, i_len=3; ar_ready=1; 4 beats, rd_last on 4th -> ar_len=3, ar_id=0, i_ack one cycle, rsp_id=0, rsp_last only on 4th beat, back to IDLE.
REQ-032 i_req and d_req same cycle, both len=0 (fixed priority) -> data AR first, d_ack first, inst AR issued after data rd_last; with ARB_ROUND_ROBIN_EN, two back-to-back ties -> inst first, then data.
REQ-033 ar_ready held low 5 cycles in ADDR -> ar_valid high, ar_addr/ar_len constant all 5 cycles; no ack until handshake.
REQ-034 rd_valid gaps (valid on alternate cycles) during len=7 burst -> exactly 8 rsp_valid pulses, data in order, rsp_last on 8th.
REQ-035 reset low during DATA after 2 of 4 beats -> next cycle ar_valid=0, rd_ready=0, rsp_valid=0; new d_req after release served normally.
